// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the 19-bit ALU: two-entry skid buffer feeding the
// register-file write port, the architectural flag register and a retire counter.
module alu_writeback_stage #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [18:0]       alu_result,
  input  logic [4:0]        alu_flags,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wb_en,
  input  logic              flag_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [18:0]       rf_wdata,
  output logic [4:0]        flags,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [18:0]       fwd_data,
  output logic [CNT_W-1:0]  retired
);

  typedef struct packed {
    logic [18:0]       result;
    logic [4:0]        flags;
    logic [ADDR_W-1:0] rd;
    logic              wb_en;
    logic              flag_en;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  entry_t             head_q, head_d;
  entry_t             skid_q, skid_d;
  logic [4:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  entry_t             inEntry;
  logic               accept;
  logic               commit;

  assign inEntry = '{result: alu_result, flags: alu_flags, rd: rd,
                     wb_en: wb_en, flag_en: flag_en};

  // in_ready is a pure decode of the state register, so the ready path toward
  // the ALU never sees out_ready combinationally.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign commit    = out_valid & out_ready;

  assign rf_we     = commit & head_q.wb_en;
  assign rf_waddr  = head_q.rd;
  assign rf_wdata  = head_q.result;
  assign fwd_valid = out_valid & head_q.wb_en;
  assign fwd_rd    = head_q.rd;
  assign fwd_data  = head_q.result;
  assign flags     = flags_q;
  assign retired   = retired_q;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_d    = skid_q;
    flags_d   = flags_q;
    retired_d = retired_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = inEntry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !commit) begin
          skid_d  = inEntry;
          state_d = FULL;
        end else if (commit && !accept) begin
          state_d = EMPTY;
        end else if (commit && accept) begin
          head_d = inEntry;
        end
      end
      FULL: begin
        if (commit) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // The committing entry's flags land in the register on this edge only.
    if (commit) begin
      retired_d = retired_q + CNT_W'(1);
      if (head_q.flag_en) begin
        flags_d = head_q.flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: a vector table for the basic handshake
// and flag behaviour, plus sequences for streaming, reset and counter wrap.
module tb_alu_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [18:0] alu_result;
  logic [4:0]  alu_flags;
  logic [3:0]  rd;
  logic        wb_en;
  logic        flag_en;
  logic        out_ready;

  logic        in_ready, out_valid, rf_we, fwd_valid;
  logic [3:0]  rf_waddr, fwd_rd;
  logic [18:0] rf_wdata, fwd_data;
  logic [4:0]  flags;
  logic [15:0] retired;

  logic        w_in_ready, w_out_valid, w_rf_we, w_fwd_valid;
  logic [3:0]  w_rf_waddr, w_fwd_rd;
  logic [18:0] w_rf_wdata, w_fwd_data;
  logic [4:0]  w_flags;
  logic [3:0]  w_retired;

  int checks = 0;
  int errors = 0;

  alu_writeback_stage #(.ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .rd(rd), .wb_en(wb_en),
    .flag_en(flag_en), .out_valid(out_valid), .out_ready(out_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags(flags),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired(retired)
  );

  // Narrow-counter copy sharing the same stimulus, used for the wrap check.
  alu_writeback_stage #(.ADDR_W(4), .CNT_W(4)) dutW (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .rd(rd), .wb_en(wb_en),
    .flag_en(flag_en), .out_valid(w_out_valid), .out_ready(out_ready),
    .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
    .flags(w_flags), .fwd_valid(w_fwd_valid), .fwd_rd(w_fwd_rd),
    .fwd_data(w_fwd_data), .retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [18:0] res;
    logic [4:0]  fl;
    logic [3:0]  rd;
    logic        wb;
    logic        fe;
    logic        orr;
    logic        eIr;
    logic        eOv;
    logic        eWe;
    logic        eFwd;
    logic [3:0]  eAddr;
    logic [18:0] eData;
    logic [4:0]  eFlags;
    logic [15:0] eRet;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkVec(int iv, int res, int fl, int rdv, int wb, int fe,
                                 int orr, int eIr, int eOv, int eWe, int eFwd,
                                 int eAddr, int eData, int eFlags, int eRet);
    vec_t v;
    v.iv = 1'(iv);       v.res = 19'(res);     v.fl = 5'(fl);
    v.rd = 4'(rdv);      v.wb = 1'(wb);        v.fe = 1'(fe);
    v.orr = 1'(orr);     v.eIr = 1'(eIr);      v.eOv = 1'(eOv);
    v.eWe = 1'(eWe);     v.eFwd = 1'(eFwd);    v.eAddr = 4'(eAddr);
    v.eData = 19'(eData); v.eFlags = 5'(eFlags); v.eRet = 16'(eRet);
    return v;
  endfunction

  task automatic applyStimulus(input logic iv, input int res, input int fl,
                               input int rdv, input logic wb, input logic fe,
                               input logic orr);
    in_valid   = iv;
    alu_result = 19'(res);
    alu_flags  = 5'(fl);
    rd         = 4'(rdv);
    wb_en      = wb;
    flag_en    = fe;
    out_ready  = orr;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    // Single entry, backpressure fill with a refused third entry, flag_en gating.
    vecs[0]  = mkVec(1, 'h7FFFF, 'b00100, 3, 1, 1, 1,  1, 0, 0, 0,  0, 0,       0,       0);
    vecs[1]  = mkVec(0, 0,       0,       0, 0, 0, 1,  1, 1, 1, 1,  3, 'h7FFFF, 0,       0);
    vecs[2]  = mkVec(0, 0,       0,       0, 0, 0, 0,  1, 0, 0, 0,  3, 'h7FFFF, 'b00100, 1);
    vecs[3]  = mkVec(1, 5,       0,       1, 1, 0, 0,  1, 0, 0, 0,  3, 'h7FFFF, 'b00100, 1);
    vecs[4]  = mkVec(1, 6,       0,       2, 1, 0, 0,  1, 1, 0, 1,  1, 5,       'b00100, 1);
    vecs[5]  = mkVec(1, 7,       0,       4, 1, 0, 0,  0, 1, 0, 1,  1, 5,       'b00100, 1);
    vecs[6]  = mkVec(1, 7,       0,       4, 1, 0, 1,  0, 1, 1, 1,  1, 5,       'b00100, 1);
    vecs[7]  = mkVec(1, 7,       0,       4, 1, 0, 1,  1, 1, 1, 1,  2, 6,       'b00100, 2);
    vecs[8]  = mkVec(0, 0,       0,       0, 0, 0, 1,  1, 1, 1, 1,  4, 7,       'b00100, 3);
    vecs[9]  = mkVec(1, 9,       'b11111, 5, 0, 0, 1,  1, 0, 0, 0,  4, 7,       'b00100, 4);
    vecs[10] = mkVec(1, 'hA,     'b01000, 6, 1, 1, 1,  1, 1, 0, 0,  5, 9,       'b00100, 4);
    vecs[11] = mkVec(0, 0,       0,       0, 0, 0, 1,  1, 1, 1, 1,  6, 'hA,     'b00100, 5);
    vecs[12] = mkVec(0, 0,       0,       0, 0, 0, 0,  1, 0, 0, 0,  6, 'hA,     'b01000, 6);

    rst = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #2;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_flags", flags, 0);
    checkOutput("reset_retired", retired, 0);
    checkOutput("reset_wdata", rf_wdata, 0);
    #(-2 + 2);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].res, vecs[i].fl, vecs[i].rd,
                    vecs[i].wb, vecs[i].fe, vecs[i].orr);
      #2;
      checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].eIr);
      checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].eOv);
      checkOutput($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].eWe);
      checkOutput($sformatf("vec%0d_fwd_valid", i), fwd_valid, vecs[i].eFwd);
      checkOutput($sformatf("vec%0d_rf_waddr", i), rf_waddr, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].eData);
      checkOutput($sformatf("vec%0d_fwd_rd", i), fwd_rd, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].eData);
      checkOutput($sformatf("vec%0d_flags", i), flags, vecs[i].eFlags);
      checkOutput($sformatf("vec%0d_retired", i), retired, vecs[i].eRet);
      nextCycle();
    end

    // Streaming: 100 back-to-back entries, one commit per cycle.
    resetDut();
    for (int k = 0; k <= 100; k++) begin
      applyStimulus(k < 100, k + 'h100, 0, k % 16, 1'b1, 1'b0, 1'b1);
      #2;
      checkOutput("stream_in_ready", in_ready, 1);
      if (k > 0) begin
        checkOutput("stream_rf_we", rf_we, 1);
        checkOutput("stream_rf_wdata", rf_wdata, k - 1 + 'h100);
        checkOutput("stream_rf_waddr", rf_waddr, (k - 1) % 16);
      end
      nextCycle();
    end
    #2;
    checkOutput("stream_retired", retired, 100);
    checkOutput("stream_drained", out_valid, 0);

    // Reset while FULL with out_ready high: nothing commits, next entry is first.
    nextCycle();
    resetDut();
    #2;
    checkOutput("midrst_pre_retired", retired, 0);
    applyStimulus(1'b1, 'h11, 'b10000, 8, 1'b1, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 'h22, 'b10000, 9, 1'b1, 1'b1, 1'b0);
    nextCycle();
    #2;
    checkOutput("midrst_full", in_ready, 0);
    rst = 1'b1;
    applyStimulus(1'b1, 'h33, 'b10000, 10, 1'b1, 1'b1, 1'b1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_rf_we", rf_we, 0);
    checkOutput("midrst_retired", retired, 0);
    checkOutput("midrst_flags", flags, 0);
    checkOutput("midrst_waddr", rf_waddr, 0);
    applyStimulus(1'b1, 'h123, 0, 7, 1'b1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("midrst_first_we", rf_we, 1);
    checkOutput("midrst_first_data", rf_wdata, 'h123);
    checkOutput("midrst_first_addr", rf_waddr, 7);
    nextCycle();
    #2;
    checkOutput("midrst_post_retired", retired, 1);

    // Counter wrap on the 4-bit instance: 17 commits take it 15 -> 0 -> 1.
    nextCycle();
    resetDut();
    for (int k = 0; k <= 18; k++) begin
      applyStimulus(k < 17, k, 0, 1, 1'b1, 1'b0, 1'b1);
      #2;
      checkOutput("wrap_retired_w", w_retired, ((k == 0) ? 0 : k - 1) % 16);
      checkOutput("wrap_retired", retired, (k == 0) ? 0 : k - 1);
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
